// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: two-port arbiter in front of a single-port synchronous
// video RAM. Port 0 (pixel fetch) has priority; port 1 (game logic) is
// protected from starvation by a saturating wait counter. Accepted accesses
// are registered onto the memory bus one cycle after the handshake, and read
// data is routed back through a {valid, port} tag pipeline matched to the
// RAM read latency, so returns stay in issue order at one access per cycle.
module vga_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 12,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 7
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One tag stage per cycle between the handshake and the cycle in which the
  // RAM presents the read word: 1 for the bus register plus RD_LAT.
  localparam int         PIPE_N     = RD_LAT + 1;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic              starve;
  logic              rd_xfer;

  logic [7:0]        wait_cnt_q, wait_cnt_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [PIPE_N-1:0] pipe_vld_q, pipe_vld_d;
  logic [PIPE_N-1:0] pipe_port_q, pipe_port_d;

  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  // Grant decision: p0 by default, p1 when p0 is idle or p1 has starved.
  // Gated by rst_n so no handshake can complete while the block is held.
  always_comb begin
    starve = (wait_cnt_q == MAX_WAIT_C);
    p1_gnt = rst_n & p1_req & (~p0_req | starve);
    p0_gnt = rst_n & p0_req & ~(starve & p1_req);
    rd_xfer = p0_gnt | (p1_gnt & ~p1_we);
  end

  // Starvation counter: counts blocked p1 cycles, saturates at the limit,
  // and restarts whenever p1 is served or withdraws its request.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_req || p1_gnt) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Memory bus register: launch the accepted access next cycle; address and
  // write data hold when idle so the RAM inputs do not toggle needlessly.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (p0_gnt) begin
      mem_en_d   = 1'b1;
      mem_addr_d = p0_addr;
    end else if (p1_gnt) begin
      mem_en_d   = 1'b1;
      mem_addr_d = p1_addr;
      if (p1_we) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = p1_wdata;
      end
    end
  end

  // Return tag pipeline: a read handshake enters stage 0 and reaches the
  // last stage exactly when its word is on mem_rdata. Writes insert a bubble.
  always_comb begin
    pipe_vld_d  = {pipe_vld_q[PIPE_N-2:0], rd_xfer};
    pipe_port_d = {pipe_port_q[PIPE_N-2:0], p1_gnt};
  end

  // Read return steering: pass mem_rdata through on the valid cycle, else
  // present the last word returned to that port.
  always_comb begin
    p0_rvalid  = pipe_vld_q[PIPE_N-1] & ~pipe_port_q[PIPE_N-1];
    p1_rvalid  = pipe_vld_q[PIPE_N-1] &  pipe_port_q[PIPE_N-1];
    p0_rdata_d = p0_rvalid ? mem_rdata : p0_rdata_q;
    p1_rdata_d = p1_rvalid ? mem_rdata : p1_rdata_q;
    p0_rdata   = p0_rdata_d;
    p1_rdata   = p1_rdata_d;
  end

  // Output wiring of the memory bus register.
  always_comb begin
    mem_en    = mem_en_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

  // State registers; reset flushes any in-flight read tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= 8'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pipe_vld_q  <= '0;
      pipe_port_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_port_q <= pipe_port_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a behavioural RAM of fixed latency.
module tb_vga_mem_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 12;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 7;

  logic              clk;
  logic              rst_n;
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_gnt, p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p1_req, p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt, p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  vga_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read-before-write, data appears RD_LAT cycles after mem_en.
  logic [DATA_W-1:0] ram [0:255];
  logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
  assign mem_rdata = rd_pipe[RD_LAT-1];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    ram[8'h10] = 12'hABC;
    for (int i = 0; i < 20; i++) ram[8'h80 + i] = 12'(12'h100 + i);
    ram[8'h52] = 12'h777;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        rd_pipe[0] <= ram[mem_addr[7:0]];
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      end
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  // Return monitor: every rvalid pulse is logged as {port, data}.
  logic [DATA_W:0] ret_q [$];
  int p0_rv_cnt = 0;
  int we_cnt    = 0;
  always @(negedge clk) begin
    if (p0_rvalid) begin
      ret_q.push_back({1'b0, p0_rdata});
      p0_rv_cnt++;
    end
    if (p1_rvalid) ret_q.push_back({1'b1, p1_rdata});
    if (mem_we) we_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"},    32'(mem_en),    32'h0);
    check({tag, "_mem_we"},    32'(mem_we),    32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_p0_gnt"},    32'(p0_gnt),    32'h0);
    check({tag, "_p1_gnt"},    32'(p1_gnt),    32'h0);
    check({tag, "_p0_rvalid"}, 32'(p0_rvalid), 32'h0);
    check({tag, "_p1_rvalid"}, 32'(p1_rvalid), 32'h0);
    check({tag, "_p0_rdata"},  32'(p0_rdata),  32'h0);
    check({tag, "_p1_rdata"},  32'(p1_rdata),  32'h0);
  endtask

  int p0_base;
  logic [DATA_W:0] exp_ret;

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b1; p0_addr = 16'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

    // Reset: all outputs low even with both requests pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Single p0 read: gnt at T, mem_en at T+1, return at T+3.
    tick();
    rst_n = 1'b1; p1_req = 1'b0;
    @(negedge clk); check("first_gnt", 32'(p0_gnt), 32'h1);
    tick(); p0_req = 1'b0;
    @(negedge clk);
    check("rd0_mem_en", 32'(mem_en), 32'h1);
    check("rd0_mem_addr", 32'(mem_addr), 32'h0010);
    check("rd0_mem_we", 32'(mem_we), 32'h0);
    tick(); @(negedge clk); check("rd0_early", 32'(p0_rvalid), 32'h0);
    tick(); @(negedge clk);
    check("rd0_rvalid", 32'(p0_rvalid), 32'h1);
    check("rd0_rdata", 32'(p0_rdata), 32'hABC);
    check("rd0_p1_rvalid", 32'(p1_rvalid), 32'h0);
    tick(); @(negedge clk);
    check("rd0_pulse", 32'(p0_rvalid), 32'h0);
    check("rd0_hold", 32'(p0_rdata), 32'hABC);

    // p1 write then read back.
    p0_base = p0_rv_cnt; we_cnt = 0;
    tick(); p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0020; p1_wdata = 12'h5A5;
    @(negedge clk);
    check("wr_p1_gnt", 32'(p1_gnt), 32'h1);
    check("wr_p0_gnt", 32'(p0_gnt), 32'h0);
    tick(); p1_req = 1'b0; p1_we = 1'b0; p1_wdata = '0;
    @(negedge clk);
    check("wr_mem_en", 32'(mem_en), 32'h1);
    check("wr_mem_we", 32'(mem_we), 32'h1);
    check("wr_mem_addr", 32'(mem_addr), 32'h0020);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h5A5);
    tick(); p1_req = 1'b1; p1_addr = 16'h0020;
    @(negedge clk); check("rb_gnt", 32'(p1_gnt), 32'h1);
    tick(); p1_req = 1'b0;
    @(negedge clk);
    check("rb_mem_we", 32'(mem_we), 32'h0);
    check("rb_mem_en", 32'(mem_en), 32'h1);
    check("rb_wdata_hold", 32'(mem_wdata), 32'h5A5);
    tick(); @(negedge clk); check("rb_early", 32'(p1_rvalid), 32'h0);
    tick(); @(negedge clk);
    check("rb_rvalid", 32'(p1_rvalid), 32'h1);
    check("rb_rdata", 32'(p1_rdata), 32'h5A5);
    tick(); @(negedge clk);
    check("idle_mem_en", 32'(mem_en), 32'h0);
    check("idle_addr_hold", 32'(mem_addr), 32'h0020);
    tick(); @(negedge clk);
    check("wr_once", 32'(we_cnt), 32'd1);
    check("wr_no_p0_rv", 32'(p0_rv_cnt - p0_base), 32'd0);

    // Starvation: p0 held, p1 raised at T, p1 granted exactly at T+7.
    tick(); p0_req = 1'b1; p0_addr = 16'h0001; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0030;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      check("stv_p1_blocked", 32'(p1_gnt), 32'h0);
      check("stv_p0_win", 32'(p0_gnt), 32'h1);
      tick();
    end
    @(negedge clk);
    check("stv_p1_gnt", 32'(p1_gnt), 32'h1);
    check("stv_p0_lose", 32'(p0_gnt), 32'h0);
    tick(); p1_req = 1'b0;
    @(negedge clk);
    check("stv_p0_regain", 32'(p0_gnt), 32'h1);
    check("stv_mem_addr", 32'(mem_addr), 32'h0030);
    tick(); p0_req = 1'b0;
    repeat (5) tick();

    // p1 withdraws at wait_cnt=5: counter restarts, 7 more blocked cycles.
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (5) tick();
    p1_req = 1'b0;
    tick(); p1_req = 1'b1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      check("drop_p1_blocked", 32'(p1_gnt), 32'h0);
      tick();
    end
    @(negedge clk); check("drop_p1_gnt", 32'(p1_gnt), 32'h1);
    tick(); p0_req = 1'b0; p1_req = 1'b0;
    repeat (6) tick();

    // Alternating reads every cycle: continuous mem_en, in-order returns.
    ret_q.delete();
    for (int i = 0; i < 20; i++) begin
      p0_req = (i % 2 == 0); p1_req = (i % 2 == 1);
      p0_addr = 16'(16'h0080 + i); p1_addr = 16'(16'h0080 + i);
      @(negedge clk);
      if (i % 2 == 0) check("alt_p0_gnt", 32'(p0_gnt), 32'h1);
      else            check("alt_p1_gnt", 32'(p1_gnt), 32'h1);
      if (i > 0) check("alt_mem_en", 32'(mem_en), 32'h1);
      tick();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk); check("alt_mem_en_last", 32'(mem_en), 32'h1);
    repeat (6) tick();
    check("alt_count", 32'(ret_q.size()), 32'd20);
    for (int i = 0; i < 20 && i < ret_q.size(); i++) begin
      exp_ret = {1'(i % 2), 12'(12'h100 + i)};
      check("alt_ret", 32'(ret_q[i]), 32'(exp_ret));
    end

    // Reset with two reads in flight: flushed, then a fresh read works.
    tick(); p0_req = 1'b1; p0_addr = 16'h0050;
    @(negedge clk); check("rst_rd0_gnt", 32'(p0_gnt), 32'h1);
    tick(); p0_req = 1'b0; p1_req = 1'b1; p1_addr = 16'h0051;
    @(negedge clk); check("rst_rd1_gnt", 32'(p1_gnt), 32'h1);
    tick(); p1_req = 1'b0; p0_req = 1'b1; rst_n = 1'b0; ret_q.delete();
    @(negedge clk);
    check_all_zero("midrst");
    tick(); tick(); p0_req = 1'b0; rst_n = 1'b1;
    repeat (6) tick();
    check("rst_no_stale", 32'(ret_q.size()), 32'd0);
    p0_req = 1'b1; p0_addr = 16'h0052;
    @(negedge clk); check("post_rst_gnt", 32'(p0_gnt), 32'h1);
    tick(); p0_req = 1'b0;
    repeat (4) tick();
    check("post_rst_count", 32'(ret_q.size()), 32'd1);
    if (ret_q.size() > 0) check("post_rst_ret", 32'(ret_q[0]), 32'h0777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
